// File: rtl/dist14x16.sv
// dist14x16: one producer fanned out to four consumers through a small in-order FIFO.
// The head word drives a shared data bus tagged by a one-hot valid that selects its port.
`ifndef DATAWIDTH
`define DATAWIDTH 16
`endif

module dist14x16 #(
    parameter int DATAWIDTH = `DATAWIDTH,
    parameter int DEPTH     = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_sel,
    input  logic [DATAWIDTH-1:0]     in_data,
    output logic [3:0]               out_valid,
    input  logic [3:0]               out_ready,
    output logic [DATAWIDTH-1:0]     out_data,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Handshake: a word moves on any rising edge where valid and ready are both high
    // on the same side; valid and data hold steady until that happens, and ready never
    // depends combinationally on valid.

    logic [1:0]           sel_mem  [DEPTH];
    logic [DATAWIDTH-1:0] data_mem [DEPTH];
    logic [AW-1:0]        wp;
    logic [AW-1:0]        rp;
    logic [CW-1:0]        count;
    logic                 push;
    logic                 pop;
    logic                 not_empty;

    assign not_empty  = (count != '0);
    assign in_ready   = reset_n && (count < CW'(DEPTH));
    assign push       = in_valid && in_ready;
    assign out_valid  = not_empty ? (4'b0001 << sel_mem[rp]) : 4'b0000;
    assign out_data   = not_empty ? data_mem[rp] : '0;
    assign pop        = |(out_valid & out_ready);
    assign fifo_count = count;

    // Storage is deliberately left uncleared by reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            sel_mem[wp]  <= in_sel;
            data_mem[wp] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_dist14x16.sv
// Bench for dist14x16: directed steps from the test plan followed by a randomized phase,
// every cycle compared against a queue-based model of the distributor.
module tb_dist14x16;

  localparam int W     = 16;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   in_sel = 2'd0;
  logic [W-1:0] in_data = '0;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready = 4'b0000;
  logic [W-1:0] out_data;
  logic [$clog2(DEPTH):0] fifo_count;

  logic [W+1:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  int npops = 0;

  always #5 clk = ~clk;

  dist14x16 #(.DATAWIDTH(W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .fifo_count (fifo_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0]   ev;
    logic [W-1:0] ed;
    ev = 4'b0000;
    ed = '0;
    if (exp_q.size() > 0) begin
      ev = 4'b0001 << exp_q[0][W+1:W];
      ed = exp_q[0][W-1:0];
    end
    check({tag, ".in_ready"},   32'(in_ready),   32'(reset_n && (exp_q.size() < DEPTH)));
    check({tag, ".out_valid"},  32'(out_valid),  32'(ev));
    check({tag, ".out_data"},   32'(out_data),   32'(ed));
    check({tag, ".fifo_count"}, 32'(fifo_count), 32'(exp_q.size()));
  endtask

  // One clock: decide transfers from the model state, advance, then compare.
  task automatic cycle(input string tag);
    bit           push;
    bit           pop;
    logic [W+1:0] word;
    push = reset_n && in_valid && (exp_q.size() < DEPTH);
    pop  = reset_n && (exp_q.size() > 0) && out_ready[exp_q[0][W+1:W]];
    word = {in_sel, in_data};
    @(posedge clk);
    #1;
    if (!reset_n) begin
      exp_q.delete();
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        npops++;
      end
      if (push) exp_q.push_back(word);
    end
    check_model(tag);
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [W-1:0] d, input logic [3:0] r);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
  endtask

  initial begin
    // Reset held with a pending producer word
    reset_n = 1'b0;
    drive(1'b1, 2'd1, 16'hDEAD, 4'b1111);
    cycle("reset0");
    cycle("reset1");
    check("reset.in_ready", 32'(in_ready), 32'd0);
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.out_data", 32'(out_data), 32'd0);
    check("reset.count", 32'(fifo_count), 32'd0);
    reset_n = 1'b1;
    drive(1'b0, 2'd0, '0, 4'b0000);
    cycle("release");
    check("release.in_ready", 32'(in_ready), 32'd1);

    // Single delivery
    drive(1'b1, 2'd2, 16'hBEEF, 4'b0100);
    cycle("single.push");
    check("single.out_valid", 32'(out_valid), 32'h4);
    check("single.out_data", 32'(out_data), 32'hBEEF);
    drive(1'b0, 2'd0, '0, 4'b0100);
    cycle("single.pop");
    check("single.count", 32'(fifo_count), 32'd0);

    // Streaming: one word per cycle, each presented right after its push edge
    npops = 0;
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 2'(i % 4), W'(i), 4'b1111);
      cycle("stream");
      check("stream.onehot", 32'(out_valid), 32'(4'b0001 << (i % 4)));
      check("stream.data", 32'(out_data), 32'(i));
    end
    drive(1'b0, 2'd0, '0, 4'b1111);
    cycle("stream.drain");
    check("stream.pops", 32'(npops), 32'd16);
    check("stream.empty", 32'(fifo_count), 32'd0);

    // Head-of-line block and full boundary
    drive(1'b1, 2'd0, 16'hAAAA, 4'b0000);
    cycle("hol.push0");
    drive(1'b1, 2'd1, 16'h5555, 4'b0000);
    cycle("hol.push1");
    check("hol.full.count", 32'(fifo_count), 32'd2);
    check("hol.full.in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 2'd2, 16'h7777, 4'b0000);
    cycle("hol.push2");
    check("hol.third.count", 32'(fifo_count), 32'd2);
    drive(1'b0, 2'd0, '0, 4'b0010);
    cycle("hol.wrongport");
    check("hol.nopop.data", 32'(out_data), 32'hAAAA);
    check("hol.nopop.count", 32'(fifo_count), 32'd2);
    drive(1'b0, 2'd0, '0, 4'b0001);
    cycle("hol.pop0");
    check("hol.next.data", 32'(out_data), 32'h5555);
    check("hol.next.valid", 32'(out_valid), 32'h2);
    check("hol.next.count", 32'(fifo_count), 32'd1);
    drive(1'b0, 2'd0, '0, 4'b0010);
    cycle("hol.pop1");
    check("hol.empty", 32'(fifo_count), 32'd0);

    // Push attempt while full and popping: refused this cycle, accepted next
    drive(1'b1, 2'd0, 16'h1111, 4'b0000);
    cycle("pp.fill0");
    drive(1'b1, 2'd1, 16'h2222, 4'b0000);
    cycle("pp.fill1");
    check("pp.full", 32'(fifo_count), 32'd2);
    drive(1'b1, 2'd2, 16'h3333, 4'b0001);
    cycle("pp.popfull");
    check("pp.count1", 32'(fifo_count), 32'd1);
    check("pp.head", 32'(out_data), 32'h2222);
    cycle("pp.accept");
    check("pp.count2", 32'(fifo_count), 32'd2);
    drive(1'b0, 2'd0, '0, 4'b1111);
    cycle("pp.drain0");
    check("pp.last", 32'(out_data), 32'h3333);
    cycle("pp.drain1");

    // Reset with words buffered
    drive(1'b1, 2'd1, 16'h0BAD, 4'b0000);
    cycle("mid.fill0");
    drive(1'b1, 2'd2, 16'h0BAE, 4'b0000);
    cycle("mid.fill1");
    reset_n = 1'b0;
    drive(1'b0, 2'd0, '0, 4'b0000);
    cycle("mid.reset");
    reset_n = 1'b1;
    cycle("mid.idle");
    check("mid.flushed.valid", 32'(out_valid), 32'd0);
    check("mid.flushed.count", 32'(fifo_count), 32'd0);
    drive(1'b1, 2'd3, 16'h1234, 4'b0000);
    cycle("mid.push");
    check("mid.new.valid", 32'(out_valid), 32'h8);
    check("mid.new.data", 32'(out_data), 32'h1234);
    drive(1'b0, 2'd0, '0, 4'b1000);
    cycle("mid.pop");

    // Randomized traffic with occasional resets
    for (int n = 0; n < 500; n++) begin
      reset_n = ($urandom_range(0, 59) != 0);
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            W'($urandom), 4'($urandom_range(0, 15)));
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
